// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler
//
// Collects single-byte strobes from a UART receiver into BYTES-wide
// little-endian words (first byte received lands in bits [7:0]) and queues
// each completed word in a small first-word-fall-through FIFO. A partial
// word that stalls for TIMEOUT_CYCLES idle cycles is discarded and counted.
//
// Parameters:
//   BYTES          - UART bytes per assembled word (word width W = 8*BYTES)
//   FIFO_AW        - FIFO address width, depth = 2**FIFO_AW words
//   TIMEOUT_CYCLES - idle cycles after which a partial word is dropped
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   rx_data[7:0] in   received byte, valid while rx_en is high
//   rx_en        in   single-cycle byte strobe
//   deq          in   pop request for the FIFO head (ignored when empty)
//   clr          in   synchronous clear of overflow and timeout_cnt
//   q[W-1:0]     out  FIFO head word, 0 while empty
//   empty        out  FIFO holds no words
//   full         out  FIFO holds 2**FIFO_AW words
//   level        out  FIFO occupancy
//   busy         out  partial word in progress
//   overflow     out  sticky: a completed word was dropped on a full FIFO
//   timeout_cnt  out  saturating count of discarded partial words
module uart_rx_word_assembler #(
    parameter int BYTES          = 4,
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_en,
    input  logic                 deq,
    input  logic                 clr,
    output logic [8*BYTES-1:0]   q,
    output logic                 empty,
    output logic                 full,
    output logic [FIFO_AW:0]     level,
    output logic                 busy,
    output logic                 overflow,
    output logic [7:0]           timeout_cnt
);

    localparam int W     = 8 * BYTES;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0] LAST_BYTE  = CW'(BYTES - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic [W-1:0]       sr_q, sr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         timeout_cnt_q, timeout_cnt_d;
    logic [W-1:0]       mem_q [DEPTH];

    logic [W-1:0]       shifted;
    logic               word_done;
    logic               timeout_hit;
    logic               pop;
    logic               push;
    logic               drop;

    // The new byte enters at the top and older bytes slide down, so after
    // BYTES strobes the first byte sits in the least significant position.
    // Shifting the concatenation keeps this legal even for BYTES == 1.
    always_comb begin
        shifted     = W'({rx_data, sr_q} >> 8);
        word_done   = rx_en && (cnt_q == LAST_BYTE);
        timeout_hit = (state_q == ASSEMBLE) && !rx_en && (idle_q == IDLE_LIMIT);
    end

    // FIFO handshake. A pop on a full FIFO frees the slot the completing
    // word needs, so push and pop may both happen even when full.
    always_comb begin
        pop  = deq && (level_q != '0);
        push = word_done && ((level_q != DEPTH_L) || pop);
        drop = word_done && (level_q == DEPTH_L) && !deq;
    end

    // Assembly state, byte count, idle timer and shift register.
    // A strobe always wins over a timeout landing in the same cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idle_d        = idle_q;
        sr_d          = sr_q;
        timeout_cnt_d = timeout_cnt_q;
        overflow_d    = overflow_q;

        if (rx_en) begin
            sr_d   = shifted;
            idle_d = '0;
            if (word_done) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ASSEMBLE;
            end
        end else if (timeout_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
            idle_d  = '0;
            sr_d    = '0;
            if (timeout_cnt_q != 8'hFF) begin
                timeout_cnt_d = timeout_cnt_q + 8'd1;
            end
        end else if (state_q == ASSEMBLE) begin
            idle_d = idle_q + 1'b1;
        end else begin
            idle_d = '0;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end

        // Clear has the last word over any same-cycle set or increment.
        if (clr) begin
            overflow_d    = 1'b0;
            timeout_cnt_d = '0;
        end
    end

    // FIFO pointers wrap naturally at 2**FIFO_AW; level tracks occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idle_q        <= '0;
            sr_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            sr_q          <= sr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Storage needs no reset: empty gating hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shifted;
        end
    end

    always_comb begin
        empty       = (level_q == '0);
        full        = (level_q == DEPTH_L);
        level       = level_q;
        busy        = (state_q == ASSEMBLE);
        overflow    = overflow_q;
        timeout_cnt = timeout_cnt_q;
        q           = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// tb_uart_rx_word_assembler
//
// Directed bench for uart_rx_word_assembler with BYTES=4, FIFO_AW=2 and
// TIMEOUT_CYCLES=16. Inputs change on the falling clock edge and outputs are
// sampled there too, half a cycle away from the active edge.
module tb_uart_rx_word_assembler;

    localparam int BYTES   = 4;
    localparam int FIFO_AW = 2;
    localparam int TIMEOUT = 16;

    logic                 clk;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_en;
    logic                 deq;
    logic                 clr;
    logic [8*BYTES-1:0]   q;
    logic                 empty;
    logic                 full;
    logic [FIFO_AW:0]     level;
    logic                 busy;
    logic                 overflow;
    logic [7:0]           timeout_cnt;

    int checks = 0;
    int errors = 0;

    uart_rx_word_assembler #(
        .BYTES          (BYTES),
        .FIFO_AW        (FIFO_AW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_en       (rx_en),
        .deq         (deq),
        .clr         (clr),
        .q           (q),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expectation.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge: holds the inputs for one rising edge, then
    // returns on the next falling edge with all strobes low again.
    task automatic apply_stimulus(input logic en, input logic [7:0] data,
                                  input logic deq_in, input logic clr_in);
        rx_en   = en;
        rx_data = data;
        deq     = deq_in;
        clr     = clr_in;
        @(negedge clk);
        rx_en   = 1'b0;
        rx_data = 8'h00;
        deq     = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Four back-to-back bytes, least significant first; deq_last pops the
    // head in the same cycle as the final byte.
    task automatic send_word(input logic [31:0] w, input logic deq_last);
        for (int i = 0; i < BYTES; i++) begin
            apply_stimulus(1'b1, w[8*i +: 8], (i == BYTES - 1) ? deq_last : 1'b0, 1'b0);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] expected);
        check_output(tag, 64'(q), 64'(expected));
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rx_data = 8'h00;
        rx_en   = 1'b0;
        deq     = 1'b0;
        clr     = 1'b0;
        rst     = 1'b0;
        #1 rst  = 1'b1;
        #2;
        // Reset values, before the first rising clock edge.
        check_output("reset_empty", 64'(empty), 64'd1);
        check_output("reset_full", 64'(full), 64'd0);
        check_output("reset_level", 64'(level), 64'd0);
        check_output("reset_q", 64'(q), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_overflow", 64'(overflow), 64'd0);
        check_output("reset_tcnt", 64'(timeout_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Spaced bytes assemble into one little-endian word.
        apply_stimulus(1'b1, 8'h78, 1'b0, 1'b0);
        check_output("first_byte_busy", 64'(busy), 64'd1);
        idle_cycles(9);
        apply_stimulus(1'b1, 8'h56, 1'b0, 1'b0);
        idle_cycles(9);
        apply_stimulus(1'b1, 8'h34, 1'b0, 1'b0);
        idle_cycles(9);
        apply_stimulus(1'b1, 8'h12, 1'b0, 1'b0);
        check_output("word1_empty", 64'(empty), 64'd0);
        check_output("word1_q", 64'(q), 64'h12345678);
        check_output("word1_level", 64'(level), 64'd1);
        check_output("word1_busy", 64'(busy), 64'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("deq_empty", 64'(empty), 64'd1);
        check_output("deq_q", 64'(q), 64'd0);

        // Pop on an empty FIFO is ignored.
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("deq_on_empty_level", 64'(level), 64'd0);
        check_output("deq_on_empty_empty", 64'(empty), 64'd1);

        // Five words into a four-deep FIFO: the fifth is dropped.
        for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b0);
        check_output("fill_full", 64'(full), 64'd1);
        check_output("fill_level", 64'(level), 64'd4);
        check_output("fill_overflow", 64'(overflow), 64'd0);
        send_word(32'd5, 1'b0);
        check_output("drop_overflow", 64'(overflow), 64'd1);
        check_output("drop_level", 64'(level), 64'd4);
        pop_expect("drop_pop1", 32'd1);
        pop_expect("drop_pop2", 32'd2);
        pop_expect("drop_pop3", 32'd3);
        pop_expect("drop_pop4", 32'd4);
        check_output("drop_drained", 64'(empty), 64'd1);
        check_output("overflow_sticky", 64'(overflow), 64'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("clr_overflow", 64'(overflow), 64'd0);

        // Completion on a full FIFO together with a pop.
        for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b0);
        send_word(32'd5, 1'b1);
        check_output("full_pop_overflow", 64'(overflow), 64'd0);
        check_output("full_pop_level", 64'(level), 64'd4);
        check_output("full_pop_full", 64'(full), 64'd1);
        pop_expect("full_pop1", 32'd2);
        pop_expect("full_pop2", 32'd3);
        pop_expect("full_pop3", 32'd4);
        pop_expect("full_pop4", 32'd5);
        check_output("full_pop_drained", 64'(empty), 64'd1);

        // Simultaneous write and pop on a partly filled FIFO.
        send_word(32'hA1B2C3D4, 1'b0);
        send_word(32'h11223344, 1'b1);
        check_output("wr_pop_level", 64'(level), 64'd1);
        pop_expect("wr_pop_q", 32'h11223344);

        // A stalled partial word times out and is discarded.
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hBB, 1'b0, 1'b0);
        idle_cycles(20);
        check_output("timeout_busy", 64'(busy), 64'd0);
        check_output("timeout_tcnt", 64'(timeout_cnt), 64'd1);
        send_word(32'h04030201, 1'b0);
        check_output("after_timeout_level", 64'(level), 64'd1);
        pop_expect("after_timeout_q", 32'h04030201);

        // Timeout boundary: still busy after 15 idle cycles, gone after 16.
        apply_stimulus(1'b1, 8'hCC, 1'b0, 1'b0);
        idle_cycles(TIMEOUT - 1);
        check_output("edge15_busy", 64'(busy), 64'd1);
        check_output("edge15_tcnt", 64'(timeout_cnt), 64'd1);
        idle_cycles(1);
        check_output("edge16_busy", 64'(busy), 64'd0);
        check_output("edge16_tcnt", 64'(timeout_cnt), 64'd2);

        // A byte landing in the timeout cycle is kept.
        apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0);
        idle_cycles(TIMEOUT - 1);
        apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
        check_output("late_byte_busy", 64'(busy), 64'd1);
        check_output("late_byte_tcnt", 64'(timeout_cnt), 64'd2);
        apply_stimulus(1'b1, 8'h33, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0, 1'b0);
        check_output("late_byte_level", 64'(level), 64'd1);
        check_output("late_byte_tcnt_after", 64'(timeout_cnt), 64'd2);
        pop_expect("late_byte_q", 32'h44332211);

        // Clear coinciding with a timeout increment wins.
        apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
        idle_cycles(TIMEOUT - 1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("clr_vs_timeout_tcnt", 64'(timeout_cnt), 64'd0);
        check_output("clr_vs_timeout_busy", 64'(busy), 64'd0);

        // 256 timeouts saturate the counter at 255.
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b1, 8'h66, 1'b0, 1'b0);
            idle_cycles(TIMEOUT);
        end
        check_output("tcnt_saturate", 64'(timeout_cnt), 64'd255);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("tcnt_clr", 64'(timeout_cnt), 64'd0);

        // Reset mid-word with stored data, between clock edges.
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
        idle_cycles(TIMEOUT);
        check_output("pre_reset_tcnt", 64'(timeout_cnt), 64'd1);
        send_word(32'h0A0B0C0D, 1'b0);
        send_word(32'h01020304, 1'b0);
        apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        check_output("pre_reset_level", 64'(level), 64'd2);
        check_output("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_empty", 64'(empty), 64'd1);
        check_output("async_rst_full", 64'(full), 64'd0);
        check_output("async_rst_level", 64'(level), 64'd0);
        check_output("async_rst_q", 64'(q), 64'd0);
        check_output("async_rst_busy", 64'(busy), 64'd0);
        check_output("async_rst_overflow", 64'(overflow), 64'd0);
        check_output("async_rst_tcnt", 64'(timeout_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(32'h04030201, 1'b0);
        check_output("post_reset_level", 64'(level), 64'd1);
        check_output("post_reset_busy", 64'(busy), 64'd0);
        check_output("post_reset_q", 64'(q), 64'h04030201);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_assembler.md
UART_RX_WORD_ASSEMBLER -- requirements
Module: uart_rx_word_assembler

Interface
REQ-001 Parameter: BYTES, 4, number of UART bytes per assembled word.
REQ-002 Parameter: FIFO_AW, 2, output FIFO address width; depth = 2**FIFO_AW words.
REQ-003 Parameter: TIMEOUT_CYCLES, 100000, idle clock cycles after which a partial word is discarded.
REQ-004 Derived width: W = 8*BYTES.
REQ-005 CLK  input  1  single clock; all logic on its rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 RX_DATA  input  8  received byte, valid only in the cycle RX_EN is high.
REQ-008 RX_EN  input  1  single-cycle byte strobe from the UART receiver.
REQ-009 DEQ  input  1  consumer pop request for the FIFO head.
REQ-010 CLR  input  1  synchronous clear of OVERFLOW and TIMEOUT_CNT only.
REQ-011 Q  output  W  FIFO head word (first-word-fall-through).
REQ-012 EMPTY  output  1  FIFO holds no words.
REQ-013 FULL  output  1  FIFO holds 2**FIFO_AW words.
REQ-014 LEVEL  output  FIFO_AW+1  FIFO occupancy.
REQ-015 BUSY  output  1  partial word in progress (byte count != 0).
REQ-016 OVERFLOW  output  1  sticky flag: a completed word was dropped.
REQ-017 TIMEOUT_CNT  output  8  saturating count of discarded partial words.

Function
REQ-018 Two states: IDLE (byte count 0) and ASSEMBLE (byte count 1..BYTES-1); BUSY = state ASSEMBLE.
REQ-019 On each RX_EN the shift register SHALL update to {RX_DATA, sr[W-1:8]}, i.e. bytes arrive LSB first and the word is little-endian.
REQ-020 Byte count SHALL increment on RX_EN and wrap to 0 on the BYTES-th byte, returning to IDLE.
REQ-021 On the BYTES-th byte the completed word {RX_DATA, sr[W-1:8]} SHALL be written to the FIFO in that same cycle; EMPTY deasserts and Q shows the word the following cycle.
REQ-022 If the FIFO is full and DEQ is low at completion, the word SHALL be dropped, OVERFLOW set to 1, and FIFO contents left unchanged.
REQ-023 If the FIFO is full and DEQ is high at completion, the pop and the write SHALL both take effect; LEVEL stays at 2**FIFO_AW and OVERFLOW is not set.
REQ-024 Simultaneous write and DEQ with the FIFO not empty SHALL keep LEVEL unchanged.
REQ-025 DEQ while EMPTY=1 SHALL be ignored, with no pointer or LEVEL change.
REQ-026 Q SHALL drive 0 while EMPTY=1.
REQ-027 Idle counter SHALL reset to 0 on every RX_EN or in IDLE, and increment every ASSEMBLE cycle without RX_EN.
REQ-028 When the idle counter reaches TIMEOUT_CYCLES-1 in ASSEMBLE without RX_EN, the next cycle SHALL be IDLE with byte count 0, the partial word discarded, and TIMEOUT_CNT incremented (saturating at 255).
REQ-029 RX_EN in the timeout cycle SHALL take priority: the byte is accepted and no timeout occurs.
REQ-030 CLR SHALL zero OVERFLOW and TIMEOUT_CNT; if it coincides with a set or increment event, CLR wins.
REQ-031 FIFO pointers SHALL wrap modulo 2**FIFO_AW; FULL = (LEVEL == 2**FIFO_AW) and EMPTY = (LEVEL == 0).

Reset
REQ-032 RST high SHALL immediately force: state IDLE, byte count 0, idle counter 0, shift register 0, FIFO pointers 0, LEVEL 0, EMPTY 1, FULL 0, Q 0, BUSY 0, OVERFLOW 0, TIMEOUT_CNT 0.
REQ-033 RST asserted mid-word or with FIFO data SHALL discard all partial and stored words; after release, the first RX_EN is byte 0 of a new word.

Verification
REQ-034 BYTES=4: bytes 0x78,0x56,0x34,0x12 on RX_EN, 10 cycles apart -> after the 4th strobe EMPTY=0, Q=0x12345678, LEVEL=1; DEQ one cycle -> EMPTY=1, Q=0.
REQ-035 Push 5 complete words 0x00000001..0x00000005 with DEQ low, FIFO_AW=2 -> FULL=1, LEVEL=4, OVERFLOW=1; pops return 1,2,3,4 in order; CLR -> OVERFLOW=0.
REQ-036 FIFO full, 5th word completes in the same cycle as DEQ -> OVERFLOW stays 0, LEVEL=4, pops return 2,3,4,5.
REQ-037 TIMEOUT_CYCLES=16: send 0xAA,0xBB, then idle 20 cycles -> BUSY=0, TIMEOUT_CNT=1; then 0x01,0x02,0x03,0x04 -> Q=0x04030201.
REQ-038 TIMEOUT_CYCLES=16: a byte arrives exactly in the timeout cycle -> no timeout, TIMEOUT_CNT unchanged, and the word completes with that byte included.
REQ-039 Assert RST after 2 bytes with LEVEL=2 -> all outputs reach reset values without a clock edge; then 4 bytes -> exactly one word, LEVEL=1.
